// File: rtl/run_detector.sv
// rtl/run_detector.sv - parametrised run-length detector FSM with event counter
//
// Flags a run of RUN_LEN consecutive matching samples on the serial input w.
//
// Ports:
//   clock         - system clock, all logic on posedge
//   reset         - synchronous active-high reset, highest priority
//   enable        - sample qualifier; w is only looked at when high
//   w             - serial data input
//   mode          - 00 run of 1s, 01 run of 0s, 10 run of either value, 11 as 00
//   retrigger     - 1: detect every cycle the run continues past RUN_LEN; 0: once per run
//   detect        - registered hit flag
//   event_count   - registered saturating count of detect assertions
//   run_length    - registered current run length, saturates at RUN_LEN
//   current_state - registered FSM state (IDLE=00, RUN=01, HIT=10, WAIT=11)
//   next_state    - combinational next state

module run_detector #(
    parameter int RUN_LEN = 4,
    parameter int CNT_W   = 8,
    localparam int RL_W   = $clog2(RUN_LEN + 1)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             enable,
    input  logic             w,
    input  logic [1:0]       mode,
    input  logic             retrigger,
    output logic             detect,
    output logic [CNT_W-1:0] event_count,
    output logic [RL_W-1:0]  run_length,
    output logic [1:0]       current_state,
    output logic [1:0]       next_state
);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        HIT  = 2'b10,
        WAIT = 2'b11
    } state_t;

    state_t           state_q, state_d;
    logic             detect_q, detect_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [RL_W-1:0]  run_q, run_d;
    logic             last_bit_q, last_bit_d;
    logic [1:0]       mode_q, mode_d;

    logic [1:0]       eff_mode;
    logic             either;
    logic             pol_match;
    logic             match;
    logic [RL_W-1:0]  run_inc;

    always_comb begin
        eff_mode  = (mode == 2'b11) ? 2'b00 : mode;
        either    = (eff_mode == 2'b10);
        pol_match = (eff_mode == 2'b01) ? ~w : w;
        // In either-value mode a run continues while the bit repeats.
        match     = either ? (w == last_bit_q) : pol_match;
        run_inc   = run_q + RL_W'(1);
    end

    always_comb begin
        state_d    = state_q;
        detect_d   = 1'b0;
        cnt_d      = cnt_q;
        run_d      = run_q;
        last_bit_d = last_bit_q;
        mode_d     = mode_q;

        if (reset) begin
            state_d    = IDLE;
            cnt_d      = '0;
            run_d      = '0;
            last_bit_d = 1'b0;
            mode_d     = 2'b00;
        end else if (enable) begin
            last_bit_d = w;
            mode_d     = mode;
            if ((state_q != IDLE) && (mode != mode_q)) begin
                // A mode change mid-run makes the partial run meaningless.
                state_d = IDLE;
                run_d   = '0;
            end else begin
                case (state_q)
                    IDLE: begin
                        if (either || pol_match) begin
                            state_d = RUN;
                            run_d   = RL_W'(1);
                        end
                    end
                    RUN: begin
                        if (match) begin
                            run_d = run_inc;
                            if (run_inc == RL_W'(RUN_LEN)) begin
                                state_d  = HIT;
                                detect_d = 1'b1;
                            end
                        end
                    end
                    HIT: begin
                        if (match) begin
                            if (retrigger) begin
                                detect_d = 1'b1;
                            end else begin
                                state_d = WAIT;
                            end
                        end
                    end
                    WAIT: begin
                    end
                endcase

                // Break rule: only either-value mode treats the breaking bit as a new start.
                if ((state_q != IDLE) && !match) begin
                    if (either) begin
                        state_d = RUN;
                        run_d   = RL_W'(1);
                    end else begin
                        state_d = IDLE;
                        run_d   = '0;
                    end
                end
            end

            if (detect_d && (cnt_q != {CNT_W{1'b1}})) begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clock) begin
        state_q    <= state_d;
        detect_q   <= detect_d;
        cnt_q      <= cnt_d;
        run_q      <= run_d;
        last_bit_q <= last_bit_d;
        mode_q     <= mode_d;
    end

    assign detect        = detect_q;
    assign event_count   = cnt_q;
    assign run_length    = run_q;
    assign current_state = state_q;
    assign next_state    = state_d;

endmodule

// File: tb/tb_run_detector.sv
// tb/tb_run_detector.sv - randomized self-checking bench for run_detector

module tb_run_detector;

    localparam int RL = 4;

    logic       clock = 1'b0;
    logic       reset, enable, w, retrigger;
    logic [1:0] mode;

    logic       det_a, det_b;
    logic [7:0] cnt_a;
    logic [1:0] cnt_b;
    logic [2:0] run_a, run_b;
    logic [1:0] st_a, st_b, nx_a, nx_b;

    always #5 clock = ~clock;

    run_detector #(.RUN_LEN(RL), .CNT_W(8)) dut_a (
        .clock(clock), .reset(reset), .enable(enable), .w(w), .mode(mode),
        .retrigger(retrigger), .detect(det_a), .event_count(cnt_a),
        .run_length(run_a), .current_state(st_a), .next_state(nx_a)
    );

    run_detector #(.RUN_LEN(RL), .CNT_W(2)) dut_b (
        .clock(clock), .reset(reset), .enable(enable), .w(w), .mode(mode),
        .retrigger(retrigger), .detect(det_b), .event_count(cnt_b),
        .run_length(run_b), .current_state(st_b), .next_state(nx_b)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference model: a run counter plus a "quiet" flag meaning the run has
    // already been reported once in one-shot fashion.
    int       m_run;
    bit       m_quiet;
    bit       m_last;
    bit [1:0] m_modeq;
    int       m_cnt;
    bit       m_det;

    function automatic int m_state();
        if (m_run == 0)       return 0;
        else if (m_run < RL)  return 1;
        else if (m_quiet)     return 3;
        else                  return 2;
    endfunction

    task automatic model_step(input bit r, input bit e, input bit wv,
                              input bit [1:0] md, input bit rt);
        bit [1:0] em;
        bit       hit;
        if (r) begin
            m_run = 0; m_quiet = 0; m_last = 0; m_modeq = 0; m_cnt = 0; m_det = 0;
        end else if (!e) begin
            m_det = 0;
        end else begin
            m_det = 0;
            em = (md == 2'd3) ? 2'd0 : md;
            if (m_run != 0 && md != m_modeq) begin
                m_run = 0; m_quiet = 0;
            end else if (m_run == 0) begin
                if (em == 2'd2 || (em == 2'd0 ? wv : !wv)) begin
                    m_run = 1; m_quiet = 0;
                end
            end else begin
                hit = (em == 2'd2) ? (wv == m_last) : (em == 2'd0 ? wv : !wv);
                if (hit) begin
                    if (m_run < RL) begin
                        m_run++;
                        if (m_run == RL) m_det = 1;
                    end else if (!rt) begin
                        m_quiet = 1;
                    end else if (!m_quiet) begin
                        m_det = 1;
                    end
                end else begin
                    m_run = (em == 2'd2) ? 1 : 0;
                    m_quiet = 0;
                end
            end
            if (m_det) m_cnt++;
            m_last = wv;
            m_modeq = md;
        end
    endtask

    task automatic cycle(input bit r, input bit e, input bit wv,
                         input bit [1:0] md, input bit rt);
        reset = r; enable = e; w = wv; mode = md; retrigger = rt;
        model_step(r, e, wv, md, rt);
        #1;
        check("next_state_a", nx_a, m_state());
        check("next_state_b", nx_b, m_state());
        @(posedge clock);
        #1;
        check("detect_a", det_a, m_det);
        check("detect_b", det_b, m_det);
        check("count_a", cnt_a, (m_cnt > 255) ? 255 : m_cnt);
        check("count_b", cnt_b, (m_cnt > 3) ? 3 : m_cnt);
        check("run_a", run_a, m_run);
        check("run_b", run_b, m_run);
        check("state_a", st_a, m_state());
        check("state_b", st_b, m_state());
    endtask

    task automatic run_bits(input string s, input bit [1:0] md, input bit rt);
        for (int i = 0; i < s.len(); i++) cycle(0, 1, (s[i] == 8'h31), md, rt);
    endtask

    task automatic do_reset();
        cycle(1, 0, 0, 2'd0, 0);
    endtask

    initial begin
        do_reset();
        check("reset_count", cnt_a, 0);
        check("reset_state", st_a, 0);
        check("reset_run", run_a, 0);

        run_bits("01111111", 2'd0, 0);
        check("t1_count", cnt_a, 1);
        check("t1_state", st_a, 3);

        do_reset();
        run_bits("01111111", 2'd0, 1);
        check("t2_count", cnt_a, 4);
        check("t2_state", st_a, 2);

        do_reset();
        run_bits("11101111", 2'd0, 0);
        check("t3_count", cnt_a, 1);

        do_reset();
        run_bits("00001111", 2'd2, 0);
        check("t4_count", cnt_a, 2);

        do_reset();
        run_bits("111111111111", 2'd0, 1);
        check("t5_count_sat", cnt_b, 3);
        check("t5_detect_sat", det_b, 1);
        check("t5_count_wide", cnt_a, 9);

        do_reset();
        run_bits("11", 2'd0, 0);
        for (int i = 0; i < 3; i++) cycle(0, 0, 0, 2'd0, 0);
        run_bits("11", 2'd0, 0);
        check("t6_enable_detect", det_a, 1);

        do_reset();
        run_bits("111", 2'd0, 0);
        do_reset();
        run_bits("1", 2'd0, 0);
        check("t6_reset_run", run_a, 1);
        check("t6_reset_detect", det_a, 0);

        do_reset();
        run_bits("11", 2'd0, 0);
        cycle(0, 1, 0, 2'd1, 0);
        check("t6_mode_state", st_a, 0);
        check("t6_mode_run", run_a, 0);

        do_reset();
        begin
            bit [1:0] md = 2'd0;
            bit       rt = 0;
            for (int i = 0; i < 4000; i++) begin
                if ($urandom_range(0, 15) == 0) md = 2'($urandom_range(0, 3));
                if ($urandom_range(0, 7) == 0)  rt = ~rt;
                cycle(($urandom_range(0, 63) == 0), ($urandom_range(0, 7) != 0),
                      1'($urandom_range(0, 1)), md, rt);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/run_detector.md
Name: run_detector

Overview:
Parametrised run-length detector FSM, the successor to the fixed 3-bit serial sequence detector. It watches the serial input w and flags a run of RUN_LEN consecutive matching samples. It adds selectable polarity, an either-value mode, retrigger/one-shot reporting, a saturating event counter, a sample-enable qualifier and synchronous reset. The state outputs stay visible for bench and debug use.

Parameters:
RUN_LEN, 4, required consecutive matching samples; legal range 2..255.
CNT_W, 8, width of event_count; legal range >= 1.
RL_W (localparam), $clog2(RUN_LEN+1), width of run_length.

Ports:
clock  input  1  single system clock; all logic on posedge.
reset  input  1  synchronous, active-high; priority over all other inputs.
enable  input  1  sample qualifier; w is sampled only when enable=1.
w  input  1  serial data input.
mode  input  2  00 = run of 1s; 01 = run of 0s; 10 = run of either value; 11 = treated as 00.
retrigger  input  1  1 = detect every cycle the run continues past RUN_LEN; 0 = detect once per run.
detect  output  1  registered hit flag.
event_count  output  CNT_W  registered saturating count of detect assertions.
run_length  output  RL_W  registered current run length; saturates at RUN_LEN.
current_state  output  2  registered FSM state.
next_state  output  2  combinational next state.

Behaviour:
- States: IDLE=00, RUN=01, HIT=10, WAIT=11.
- Reset, synchronous:
  - state=IDLE, detect=0, event_count=0, run_length=0, last_bit=0, mode_q=00.
  - next_state reads IDLE while reset=1.
- enable=0:
  - state, run_length, event_count and last_bit hold.
  - detect is forced to 0 on that edge.
  - next_state equals current_state.
- Match rule for an enabled sample:
  - mode 00/11: match when w=1.
  - mode 01: match when w=0.
  - mode 10: in IDLE, any value starts a run; otherwise match when w==last_bit.
  - last_bit is updated on every enabled sample.
- mode_q registers mode on every enabled edge.
  - If mode != mode_q while state != IDLE, the sample is discarded: go IDLE, run_length=0, detect=0.
- IDLE:
  - A starting sample sets run_length=1. Go RUN, or HIT if RUN_LEN would be reached (impossible since RUN_LEN>=2).
  - Otherwise stay IDLE.
- RUN:
  - On a match, run_length+1. When the result equals RUN_LEN, go HIT: detect=1, event_count+1.
  - On a non-match, apply the break rule.
- HIT:
  - On a match with retrigger=1, stay HIT: detect=1, event_count+1.
  - On a match with retrigger=0, go WAIT: detect=0.
  - run_length stays at RUN_LEN.
  - On a non-match, apply the break rule.
- WAIT:
  - On a match, stay WAIT: detect=0.
  - On a non-match, apply the break rule.
- Break rule (non-match in RUN/HIT/WAIT):
  - detect=0.
  - If the breaking sample is itself a valid starter (mode 10; or mode 00/01 cannot occur), go RUN with run_length=1.
  - Otherwise go IDLE with run_length=0.
- Latency: detect is high in the cycle following the clock edge that captured the RUN_LEN-th matching sample.
- event_count saturates at 2^CNT_W-1 and never wraps; detect still asserts at saturation.
- retrigger is evaluated each cycle. Changing it in HIT takes effect on the next match.
- Reset mid-run discards the partial run. The first post-reset sample starts from IDLE.

Test Plan:
1. RUN_LEN=4, mode 00, retrigger 0; reset, then enabled w=0,1,1,1,1,1,1,1 -> run_length 0,1,2,3,4,4,4,4; detect high exactly one cycle after the 4th 1; event_count=1; state ends WAIT(11).
2. Same stream with retrigger=1 -> detect high 4 consecutive cycles; event_count=4; state HIT(10).
3. Mode 00, w=1,1,1,0,1,1,1,1 -> no detect in the first run; run_length returns to 0 on the 0; single detect after the 8th sample; event_count=1.
4. Mode 10, retrigger 0, w=0,0,0,0,1,1,1,1 -> detect after the 4th 0 and after the 4th 1; the 1 that breaks the 0-run restarts run_length=1; event_count=2.
5. CNT_W=2, mode 00, retrigger 1, 12 consecutive 1s -> event_count climbs to 3 and holds; detect stays high.
6. Interruptions:
   - Mode 00, w=1,1, then enable=0 for 3 cycles with w=0, then w=1,1 enabled -> detect after the 4th enabled 1.
   - Separately, reset asserted after three 1s, then one 1 -> run_length=1, no detect.
   - Mode switched 00->01 mid-run -> state IDLE, run_length=0.
